// File: rtl/fp_add_normalize_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_normalize_if
// Description : Operand/result bundle for the FP32 add-normalise stage.
//               Input side: in_valid/in_ready handshake carrying op, signs,
//               common exponent and two aligned mantissas (hidden bit incl.).
//               Output side: out_valid/out_ready handshake carrying the packed
//               FP32 result plus overflow/underflow/zero flags.
//               master = producer/consumer side, slave = the stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_add_normalize_if #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   op;
    logic                   sign_a;
    logic                   sign_b;
    logic [EXP_W-1:0]       exp_in;
    logic [MAN_W-1:0]       al_man_a;
    logic [MAN_W-1:0]       al_man_b;
    logic [EXP_W+MAN_W-1:0] result;
    logic                   out_valid;
    logic                   out_ready;
    logic                   overflow;
    logic                   underflow;
    logic                   zero;

    modport master (
        output in_valid, op, sign_a, sign_b, exp_in, al_man_a, al_man_b, out_ready,
        input  in_ready, result, out_valid, overflow, underflow, zero
    );

    modport slave (
        input  in_valid, op, sign_a, sign_b, exp_in, al_man_a, al_man_b, out_ready,
        output in_ready, result, out_valid, overflow, underflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/fp_add_normalize.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_normalize
// Description : Back end of the FP32 adder. Performs the effective add or
//               subtract of exponent-aligned mantissas, normalises one bit
//               per cycle, and packs an IEEE-754 single result (truncation,
//               flush-to-zero).
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous reset, active low
//               bus    - fp_add_normalize_if.slave (operand and result
//                        valid/ready handshakes, result flags)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_normalize #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fp_add_normalize_if.slave  bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADD  = 2'd1;
    localparam logic [1:0] c_NORM = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam int              c_RES_W   = EXP_W + MAN_W;
    localparam logic [EXP_W:0]  c_EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0]  c_EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    logic [1:0]         r_state;
    logic               r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [MAN_W-1:0]   r_man_a;
    logic [MAN_W-1:0]   r_man_b;
    logic [EXP_W:0]     r_exp;      // one extra bit so a carry past 255 is visible
    logic [MAN_W:0]     r_sum;      // one extra bit for the addition carry
    logic               r_sign;
    logic [c_RES_W-1:0] r_result;
    logic               r_overflow;
    logic               r_underflow;
    logic               r_zero;
    logic               r_out_valid;
    logic               r_in_ready;

    logic               w_eff_b;
    logic [MAN_W:0]     w_a_ext;
    logic [MAN_W:0]     w_b_ext;
    logic [EXP_W:0]     w_exp_inc;

    assign w_eff_b   = r_sign_b ^ r_op;
    assign w_a_ext   = {1'b0, r_man_a};
    assign w_b_ext   = {1'b0, r_man_b};
    assign w_exp_inc = r_exp + c_EXP_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_op        <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_man_a     <= '0;
            r_man_b     <= '0;
            r_exp       <= '0;
            r_sum       <= '0;
            r_sign      <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= bus.op;
                        r_sign_a   <= bus.sign_a;
                        r_sign_b   <= bus.sign_b;
                        r_man_a    <= bus.al_man_a;
                        r_man_b    <= bus.al_man_b;
                        r_exp      <= {1'b0, bus.exp_in};
                        r_in_ready <= 1'b0;
                        r_state    <= c_ADD;
                    end
                end

                c_ADD: begin
                    // Subtract the smaller magnitude from the larger so the
                    // sum is always a non-negative magnitude.
                    if (r_sign_a == w_eff_b) begin
                        r_sum  <= w_a_ext + w_b_ext;
                        r_sign <= r_sign_a;
                    end else if (r_man_a >= r_man_b) begin
                        r_sum  <= w_a_ext - w_b_ext;
                        r_sign <= r_sign_a;
                    end else begin
                        r_sum  <= w_b_ext - w_a_ext;
                        r_sign <= w_eff_b;
                    end
                    r_state <= c_NORM;
                end

                c_NORM: begin
                    if (r_sum == '0) begin
                        r_result    <= '0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_zero      <= 1'b1;
                        r_state     <= c_DONE;
                    end else if (r_sum[MAN_W]) begin
                        // Carry out: one right shift, dropping the LSB.
                        r_underflow <= 1'b0;
                        r_zero      <= 1'b0;
                        if (w_exp_inc >= c_EXP_MAX) begin
                            r_result   <= {r_sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
                            r_overflow <= 1'b1;
                        end else begin
                            r_result   <= {r_sign, w_exp_inc[EXP_W-1:0], r_sum[MAN_W-1:1]};
                            r_overflow <= 1'b0;
                        end
                        r_state <= c_DONE;
                    end else if (r_sum[MAN_W-1]) begin
                        r_overflow <= 1'b0;
                        if (r_exp == '0) begin
                            r_result    <= '0;
                            r_underflow <= 1'b1;
                            r_zero      <= 1'b1;
                        end else begin
                            r_result    <= {r_sign, r_exp[EXP_W-1:0], r_sum[MAN_W-2:0]};
                            r_underflow <= 1'b0;
                            r_zero      <= 1'b0;
                        end
                        r_state <= c_DONE;
                    end else if (r_exp > c_EXP_ONE) begin
                        r_sum <= {r_sum[MAN_W-1:0], 1'b0};
                        r_exp <= r_exp - c_EXP_ONE;
                    end else begin
                        // Would go subnormal: flush to zero.
                        r_result    <= '0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b1;
                        r_zero      <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end

                c_DONE: begin
                    // out_valid rises one cycle after the result registers load.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.result    = r_result;
    assign bus.out_valid = r_out_valid;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
    assign bus.zero      = r_zero;

endmodule
`default_nettype wire
